// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity and one stop bit.
// Each bit lasts Prescale CLK cycles; a Prescale of 0 gives 64 cycles per bit.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q;
  logic [5:0]            edge_cnt_q;
  logic [5:0]            presc_q;
  logic [3:0]            bit_cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] sh_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  tx_q;
  logic                  busy_q;

  logic bit_end;
  logic last_data;

  // 6-bit wrap makes a latched Prescale of 0 behave as 64.
  assign bit_end   = (edge_cnt_q == presc_q - 6'd1);
  assign last_data = (bit_cnt_q == 4'(DATA_WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      presc_q    <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      sh_q       <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      if (state_q == IDLE || bit_end) begin
        edge_cnt_q <= '0;
      end else begin
        edge_cnt_q <= edge_cnt_q + 6'd1;
      end

      case (state_q)
        IDLE: begin
          if (Data_Valid) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            presc_q   <= Prescale;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt_q <= '0;
            tx_q      <= data_q[0];
            sh_q      <= data_q >> 1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (!last_data) begin
              tx_q <= sh_q[0];
              sh_q <= sh_q >> 1;
            end else if (par_en_q) begin
              tx_q    <= (^data_q) ^ par_typ_q;
              state_q <= PARITY;
            end else begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: expected line bits are queued when a request is
// driven and checked cycle by cycle against TX_OUT/Busy as the frame is sent.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic lvl;
    int   per;
  } bit_t;

  bit_t exp_q[$];
  int   len_q[$];

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic [5:0] presc);
    int   p;
    int   ones;
    bit_t b;
    p    = (presc == 6'd0) ? 64 : int'(presc);
    ones = 0;
    b.per = p;
    b.lvl = 1'b0;
    exp_q.push_back(b);
    for (int i = 0; i < 8; i++) begin
      b.lvl = d[i];
      if (d[i]) ones++;
      exp_q.push_back(b);
    end
    if (pen) begin
      b.lvl = ((ones % 2) == 1) ? ~ptyp : ptyp;
      exp_q.push_back(b);
    end
    b.lvl = 1'b1;
    exp_q.push_back(b);
    len_q.push_back(pen ? 11 : 10);
  endtask

  task automatic req(input logic [7:0] d, input logic pen, input logic ptyp,
                     input logic [5:0] presc);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Prescale   = presc;
    Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
  endtask

  // mode 0: plain; 1: mid-frame request/config disturbance at cycle 'at';
  // 2: P_DATA change at 'at'; 3: reset at cycle 'at', frame abandoned.
  task automatic check_frame(input int exp_busy, input int mode, input int at);
    int   n;
    int   cyc;
    int   busy_cnt;
    bit_t b;
    n        = len_q.pop_front();
    cyc      = 0;
    busy_cnt = 0;
    for (int k = 0; k < n; k++) begin
      b = exp_q.pop_front();
      for (int c = 0; c < b.per; c++) begin
        if (mode == 3 && cyc == at) begin
          RST = 1'b1;
          tick();
          chk("reset_mid_frame", {30'd0, Busy, TX_OUT}, 32'd1);
          RST = 1'b0;
          for (int j = k + 1; j < n; j++) b = exp_q.pop_front();
          return;
        end
        chk($sformatf("frame_bit%0d_cyc%0d", k, c), {30'd0, Busy, TX_OUT}, {30'd0, 1'b1, b.lvl});
        if (Busy === 1'b1) busy_cnt++;
        if (mode == 1 && cyc == at) begin
          Data_Valid = 1'b1;
          Prescale   = 6'd4;
          PAR_TYP    = 1'b1;
          P_DATA     = ~P_DATA;
        end
        if (mode == 1 && cyc == at + 1) Data_Valid = 1'b0;
        if (mode == 2 && cyc == at) P_DATA = 8'hC3;
        tick();
        cyc++;
      end
    end
    chk("idle_after_frame", {30'd0, Busy, TX_OUT}, 32'd1);
    chk("busy_cycles", busy_cnt, exp_busy);
  endtask

  initial begin
    RST        = 1'b1;
    Data_Valid = 1'b0;
    P_DATA     = 8'h00;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_state", {30'd0, Busy, TX_OUT}, 32'd1);
    end
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_no_request", {30'd0, Busy, TX_OUT}, 32'd1);
    end

    push_frame(8'hA5, 1'b1, 1'b0, 6'd8);
    req(8'hA5, 1'b1, 1'b0, 6'd8);
    check_frame(88, 0, 0);

    push_frame(8'h00, 1'b1, 1'b1, 6'd16);
    req(8'h00, 1'b1, 1'b1, 6'd16);
    check_frame(176, 0, 0);

    push_frame(8'h00, 1'b0, 1'b1, 6'd16);
    req(8'h00, 1'b0, 1'b1, 6'd16);
    check_frame(160, 0, 0);

    // Back-to-back with Data_Valid held high across both frames
    push_frame(8'h3C, 1'b0, 1'b0, 6'd4);
    push_frame(8'hC3, 1'b0, 1'b0, 6'd4);
    P_DATA     = 8'h3C;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd4;
    Data_Valid = 1'b1;
    tick();
    check_frame(40, 2, 5);
    tick();
    Data_Valid = 1'b0;
    check_frame(40, 0, 0);

    push_frame(8'h5A, 1'b1, 1'b0, 6'd8);
    req(8'h5A, 1'b1, 1'b0, 6'd8);
    check_frame(88, 1, 20);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("no_extra_frame", {30'd0, Busy, TX_OUT}, 32'd1);
    end

    // Reset and request in the same cycle: request dropped
    P_DATA     = 8'hFF;
    Prescale   = 6'd4;
    Data_Valid = 1'b1;
    RST        = 1'b1;
    tick();
    chk("reset_with_request", {30'd0, Busy, TX_OUT}, 32'd1);
    RST        = 1'b0;
    Data_Valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("request_dropped", {30'd0, Busy, TX_OUT}, 32'd1);
    end

    // Prescale 0 (64 cycles/bit), reset during data bit 3
    push_frame(8'h01, 1'b0, 1'b0, 6'd0);
    req(8'h01, 1'b0, 1'b0, 6'd0);
    check_frame(0, 3, 276);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_after_abort", {30'd0, Busy, TX_OUT}, 32'd1);
    end
    push_frame(8'h01, 1'b1, 1'b0, 6'd0);
    req(8'h01, 1'b1, 1'b0, 6'd0);
    check_frame(704, 0, 0);

    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the UART block: serialises one parallel data word per request into a start bit, LSB-first data bits, optional parity and one stop bit on `TX_OUT`. Each bit lasts `Prescale` cycles of `CLK`, the same oversampling clock and prescale that the UART receiver uses, so both ends agree on bit period. `Busy` gives the upstream (FIFO or register interface) a one-word-at-a-time handshake.

## Interface
- `DATA_WIDTH`, 8, number of data bits per frame (1..15)
- `CLK`  input  1  system / oversampling clock, all logic on rising edge
- `RST`  input  1  synchronous, active-high reset
- `P_DATA`  input  DATA_WIDTH  parallel word to transmit
- `Data_Valid`  input  1  request; accepted only in a cycle where `Busy`=0
- `PAR_EN`  input  1  1 = append parity bit
- `PAR_TYP`  input  1  0 = even parity, 1 = odd parity
- `Prescale`  input  6  CLK cycles per bit; 0 means 64
- `TX_OUT`  output  1  serial line, idle high, registered
- `Busy`  output  1  high while a frame is in progress, registered

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on `Data_Valid`=1.
  - START -> DATA after one bit period.
  - DATA -> PARITY after DATA_WIDTH bit periods if latched PAR_EN=1, else DATA -> STOP.
  - PARITY -> STOP after one bit period.
  - STOP -> IDLE after one bit period.
- Acceptance in IDLE latches `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale`. Input changes during a frame have no effect on it.
- `Data_Valid` while `Busy`=1 is ignored. There is no queueing and no error flag.
- Line levels by state: START drives 0; DATA drives latched data bit 0 first, up to bit DATA_WIDTH-1; STOP and IDLE drive 1.
- PARITY drives the XOR of all latched data bits XOR `PAR_TYP`. This gives an even total number of ones for `PAR_TYP`=0 and an odd total for `PAR_TYP`=1.
- Edge counter (6 bit) runs 0 .. Prescale_latched-1 and wraps at the end of each bit. The end-of-bit compare uses 6-bit arithmetic, so Prescale=0 gives 64 cycles per bit and Prescale=1 gives 1 cycle per bit.
- A 4-bit bit counter indexes the data bits. It clears on entry to DATA and increments at each DATA bit end.
- Reset: state IDLE, `TX_OUT`=1, `Busy`=0, counters 0, latched registers 0.
- Reset mid-frame: the next cycle shows `TX_OUT`=1 and `Busy`=0, and the frame is abandoned without a stop bit.
- Reset and `Data_Valid` in the same cycle: reset wins and the request is dropped.

## Timing
- Frame length F = 1 + DATA_WIDTH + PAR_EN + 1 bits. P = latched Prescale, or 64 if 0.
- Request accepted at cycle N: `TX_OUT`=0 and `Busy`=1 starting at cycle N+1. There is exactly 1 cycle of latency.
- Bit k (k=0 is start) occupies cycles N+1+k·P .. N+(k+1)·P.
- `Busy`=1 for cycles N+1 .. N+F·P, exactly F·P cycles.
- First cycle of IDLE is N+F·P+1, with `Busy`=0 and `TX_OUT`=1.
- Earliest next acceptance is at cycle N+F·P+1, with its start bit at N+F·P+2. Back-to-back frames are therefore separated by exactly 1 idle-high cycle.
- `Busy` and `TX_OUT` change only on the rising edge of `CLK` and never glitch.

## Test plan
- Reset, idle check: hold `RST`=1 for 3 cycles, then release. Required: `TX_OUT`=1 and `Busy`=0 throughout, and no frame starts without `Data_Valid`.
- Even parity, 8'hA5: Prescale=8, PAR_EN=1, PAR_TYP=0. Required line sequence is 0,1,0,1,0,0,1,0,1,0,1, each bit 8 cycles. `Busy` high for exactly 88 cycles, starting 1 cycle after acceptance.
- Odd parity and no parity, 8'h00: Prescale=16, PAR_EN=1, PAR_TYP=1 gives parity bit 1 and 176 busy cycles. Repeat with PAR_EN=0: 10 bits and 160 busy cycles.
- Back-to-back: send 8'h3C, then 8'hC3 with `Data_Valid` held high continuously, Prescale=4, PAR_EN=0. Required: exactly one idle-high cycle between the stop bit of frame 1 and the start bit of frame 2. `P_DATA` changes during frame 1 do not corrupt it.
- Ignored inputs mid-frame: during the DATA state, pulse `Data_Valid` and change `Prescale` from 8 to 4 and `PAR_TYP` from 0 to 1. Required: the current frame keeps 8-cycle bits and even parity, and no extra frame is sent.
- Prescale=0 and reset mid-frame: send 8'h01 with Prescale=0. Required: 64 cycles per bit. Assert `RST` during data bit 3. Required: the next cycle shows `TX_OUT`=1 and `Busy`=0, and a new request after release transmits a full, correct frame.
